fc_argmax: RTL and testbench
============================

FC_ARGMAX -- requirements
Module: fc_argmax

Interface
REQ-001 Parameter NUM_CLASSES, default 10, SHALL set the number of FC scores per frame (2..16).
REQ-002 Parameter SW, default 17, SHALL set the score width; scores are signed two's complement.
REQ-003 clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 score_in_valid  input  1  SHALL flag a valid score on score_in.
REQ-006 score_in_ready  output  1  SHALL indicate the block accepts a score this cycle.
REQ-007 score_in  input  SW  SHALL carry one FC node output, in node order 0..NUM_CLASSES-1.
REQ-008 score_in_last  input  1  SHALL mark the final score of a frame; it is sampled only on a handshake.
REQ-009 class_out_valid  output  1  SHALL flag a valid classification.
REQ-010 class_out_ready  input  1  SHALL indicate the consumer accepts class_out.
REQ-011 class_out  output  4  SHALL carry the winning node index.
REQ-012 frame_err  output  1  SHALL be a sticky flag for a framing mismatch.

Function
REQ-013 An input handshake SHALL occur when score_in_valid and score_in_ready are both high at a rising edge; an output handshake SHALL occur when class_out_valid and class_out_ready are both high.
REQ-014 The FSM SHALL have exactly two states:
- COLLECT: score_in_ready=1, class_out_valid=0.
- HOLD: score_in_ready=0, class_out_valid=1.
REQ-015 In COLLECT, a node counter idx (0..NUM_CLASSES-1) SHALL increment on each input handshake.
REQ-016 On the handshake with idx=0, best_score and best_idx SHALL load the incoming score and 0 unconditionally.
REQ-017 On later handshakes, best_score and best_idx SHALL update only if score_in > best_score using a signed compare. Ties therefore keep the lower index.
REQ-018 The handshake with idx=NUM_CLASSES-1 SHALL:
- move the FSM to HOLD;
- reset idx to 0;
- make class_out_valid high on the following cycle (latency 1 cycle after the last score).
REQ-019 class_out SHALL equal best_idx, and SHALL stay stable while in HOLD until the output handshake.
REQ-020 An output handshake in HOLD SHALL return the FSM to COLLECT on the next cycle. A new frame's first score SHALL NOT be accepted in the same cycle as the output handshake (no bypass).
REQ-021 If score_in_last=1 is accepted with idx≠NUM_CLASSES-1, frame_err SHALL set. The partial frame SHALL be discarded (idx←0, stay in COLLECT).
REQ-022 If score_in_last=0 is accepted with idx=NUM_CLASSES-1, frame_err SHALL set, but the frame SHALL still complete normally.
REQ-023 frame_err SHALL clear only on reset.
REQ-024 class_out_valid SHALL NOT drop without an output handshake, whatever happens on the score inputs.
REQ-025 Inputs SHALL be ignored while score_in_ready=0.

Reset
REQ-026 While rst=1 at a rising edge, the block SHALL reset to:
- FSM = COLLECT, idx = 0;
- best_score = 0, best_idx = 0;
- class_out = 0, class_out_valid = 0, frame_err = 0.
REQ-027 After reset, score_in_ready SHALL read 1.
REQ-028 Reset during COLLECT or HOLD SHALL abandon the frame; no class_out_valid pulse SHALL follow.

Configuration
REQ-029 With macro FC_ARGMAX_SCORE_OUT_EN defined, the block SHALL:
- add output port class_score (SW bits) carrying best_score;
- keep class_score valid and stable under the same rules as class_out.
REQ-030 With FC_ARGMAX_SCORE_OUT_EN undefined, the class_score port and any logic that exists only for it SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 Scores {5,-3,12,7,0,12,-20,1,2,3} with last on the 10th and class_out_ready=1 -> class_out=2 one cycle after the 10th handshake; class_score=12 if enabled.
REQ-032 All ten scores = -65536 -> class_out=0 (lowest-index tie, most-negative compare correct).
REQ-033 Valid frame with class_out_ready=0 for 20 cycles -> class_out_valid held, score_in_ready=0, class_out stable; a ready pulse -> exactly one output handshake, then score_in_ready=1 one cycle later.
REQ-034 score_in_last=1 on the 4th score -> frame_err=1, no class_out_valid; the next clean frame {0..9 ascending} -> class_out=9.
REQ-035 rst asserted in HOLD, then in COLLECT after 5 scores -> all outputs at reset values; no stale class_out_valid afterwards.
REQ-036 score_in_valid toggled randomly with gaps -> result matches a reference argmax over 1000 random frames.

Source files
------------

// File: rtl/fc_argmax.sv
// Argmax over NUM_CLASSES signed FC scores per frame; class_out 1 cycle after the last score, held until accepted.
// Optional FC_ARGMAX_SCORE_OUT_EN adds class_score (winning score); input stalls while a result is pending.
module fc_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int SW          = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 score_in_valid,
  output logic                 score_in_ready,
  input  logic signed [SW-1:0] score_in,
  input  logic                 score_in_last,
  output logic                 class_out_valid,
  input  logic                 class_out_ready,
  output logic [3:0]           class_out,
  output logic                 frame_err
`ifdef FC_ARGMAX_SCORE_OUT_EN
  ,
  output logic signed [SW-1:0] class_score
`endif
);

  typedef enum logic {COLLECT, HOLD} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

  state_t               r_state;
  logic [3:0]           r_idx;
  logic signed [SW-1:0] r_best_score;
  logic [3:0]           r_best_idx;
  logic                 r_ready;
  logic                 r_valid;
  logic                 r_frame_err;

  logic w_in_hs;
  logic w_out_hs;
  logic w_at_last;
  logic w_take;

  assign w_in_hs   = score_in_valid & r_ready;
  assign w_out_hs  = r_valid & class_out_ready;
  assign w_at_last = (r_idx == LAST_IDX);
  // Strict greater-than keeps the lower index on ties.
  assign w_take    = (r_idx == 4'd0) | (score_in > r_best_score);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= COLLECT;
      r_idx        <= 4'd0;
      r_best_score <= '0;
      r_best_idx   <= 4'd0;
      r_ready      <= 1'b1;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_in_hs) begin
            if (w_take) begin
              r_best_score <= score_in;
              r_best_idx   <= r_idx;
            end
            if (w_at_last) begin
              r_state <= HOLD;
              r_idx   <= 4'd0;
              r_ready <= 1'b0;
              r_valid <= 1'b1;
              if (!score_in_last) r_frame_err <= 1'b1;
            end else if (score_in_last) begin
              // Early last: drop the partial frame and resynchronise on the next score.
              r_idx       <= 4'd0;
              r_frame_err <= 1'b1;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        HOLD: begin
          if (w_out_hs) begin
            r_state <= COLLECT;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign score_in_ready  = r_ready;
  assign class_out_valid = r_valid;
  assign class_out       = r_best_idx;
  assign frame_err       = r_frame_err;
`ifdef FC_ARGMAX_SCORE_OUT_EN
  assign class_score     = r_best_score;
`endif

endmodule

// File: tb/tb_fc_argmax.sv
// Directed + random scoreboard bench for fc_argmax.
module tb_fc_argmax;
  localparam int NC = 10;
  localparam int SW = 17;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 score_in_valid = 1'b0;
  logic                 score_in_last = 1'b0;
  logic                 class_out_ready = 1'b0;
  logic signed [SW-1:0] score_in = '0;
  logic                 score_in_ready;
  logic                 class_out_valid;
  logic [3:0]           class_out;
  logic                 frame_err;
`ifdef FC_ARGMAX_SCORE_OUT_EN
  logic signed [SW-1:0] class_score;
  logic signed [SW-1:0] exps_q[$];
`endif

  fc_argmax #(.NUM_CLASSES(NC), .SW(SW)) dut (
    .clk(clk), .rst(rst),
    .score_in_valid(score_in_valid), .score_in_ready(score_in_ready),
    .score_in(score_in), .score_in_last(score_in_last),
    .class_out_valid(class_out_valid), .class_out_ready(class_out_ready),
    .class_out(class_out), .frame_err(frame_err)
`ifdef FC_ARGMAX_SCORE_OUT_EN
    , .class_score(class_score)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_q[$];
  int n_out = 0;
  bit pend = 0;
  bit rnd_done = 0;
  logic [3:0] prev_cls = '0;
  logic signed [SW-1:0] frm [NC];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  function automatic int ref_argmax();
    int b = 0;
    for (int i = 1; i < NC; i++)
      if (frm[i] > frm[b]) b = i;
    return b;
  endfunction

  // Output monitor: hold rules and scoreboard pops at each output handshake.
  always @(negedge clk) begin
    if (rst) begin
      pend = 0;
    end else begin
      if (pend) begin
        check("hold_valid", 32'(class_out_valid), 32'd1);
        check("hold_stable", 32'(class_out), 32'(prev_cls));
      end
      if (class_out_valid && class_out_ready) begin
        n_out++;
        check("out_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("class_out", 32'(class_out), 32'(exp_q.pop_front()));
`ifdef FC_ARGMAX_SCORE_OUT_EN
        if (exps_q.size() > 0) check("class_score", 32'(class_score), 32'(exps_q.pop_front()));
`endif
      end
      pend = class_out_valid && !class_out_ready;
      prev_cls = class_out;
    end
  end

  task automatic send_score(input logic signed [SW-1:0] s, input bit last);
    int n = 0;
    score_in_valid = 1'b1;
    score_in = s;
    score_in_last = last;
    @(negedge clk);
    while (!score_in_ready && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (!score_in_ready) check("in_timeout", 32'(score_in_ready), 32'd1);
    @(posedge clk); #1;
    score_in_valid = 1'b0;
    score_in_last = 1'b0;
  endtask

  task automatic send_frame(input int last_at, input int max_gap, input bit push);
    if (push) begin
      exp_q.push_back(ref_argmax());
`ifdef FC_ARGMAX_SCORE_OUT_EN
      exps_q.push_back(frm[ref_argmax()]);
`endif
    end
    for (int i = 0; i < NC; i++) begin
      send_score(frm[i], i == last_at);
      if (max_gap > 0 && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, max_gap)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!score_in_ready && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check("idle_timeout", 32'(score_in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    score_in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    check({tag, "_ready"}, 32'(score_in_ready), 32'd1);
    check({tag, "_valid"}, 32'(class_out_valid), 32'd0);
    check({tag, "_cls"}, 32'(class_out), 32'd0);
    check({tag, "_err"}, 32'(frame_err), 32'd0);
`ifdef FC_ARGMAX_SCORE_OUT_EN
    check({tag, "_score"}, 32'(class_score), 32'd0);
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    int n0;
    int n;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_vals("rst0");

    // Mixed frame with a tie at 12 (indices 2 and 5).
    class_out_ready = 1'b1;
    frm = '{17'sd5, -17'sd3, 17'sd12, 17'sd7, 17'sd0, 17'sd12, -17'sd20, 17'sd1, 17'sd2, 17'sd3};
    send_frame(NC - 1, 0, 1);
    @(negedge clk);
    check("lat_valid", 32'(class_out_valid), 32'd1);
    check("lat_cls", 32'(class_out), 32'd2);
`ifdef FC_ARGMAX_SCORE_OUT_EN
    check("lat_score", 32'(class_score), 32'(17'sd12));
`endif
    @(posedge clk); #1;
    @(negedge clk);
    check("ret_ready", 32'(score_in_ready), 32'd1);
    check("ret_valid", 32'(class_out_valid), 32'd0);
    @(posedge clk); #1;

    // All most-negative.
    for (int i = 0; i < NC; i++) frm[i] = -17'sd65536;
    send_frame(NC - 1, 0, 1);
    wait_idle();

    // Stalled consumer with junk on the input side.
    class_out_ready = 1'b0;
    frm = '{17'sd3, 17'sd1, 17'sd4, 17'sd1, 17'sd5, 17'sd9, 17'sd2, 17'sd6, 17'sd5, 17'sd3};
    send_frame(NC - 1, 0, 1);
    n0 = n_out;
    score_in_valid = 1'b1;
    score_in = 17'sd30000;
    score_in_last = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(class_out_valid), 32'd1);
      check("stall_ready", 32'(score_in_ready), 32'd0);
      check("stall_cls", 32'(class_out), 32'd5);
    end
    @(posedge clk); #1;
    score_in_valid = 1'b0;
    score_in_last = 1'b0;
    class_out_ready = 1'b1;
    @(posedge clk); #1;
    class_out_ready = 1'b0;
    @(negedge clk);
    check("pulse_ready", 32'(score_in_ready), 32'd1);
    check("pulse_valid", 32'(class_out_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("pulse_one_hs", 32'(n_out - n0), 32'd1);
    @(posedge clk); #1;

    // Early last on the 4th score, then a clean ascending frame.
    for (int i = 0; i < NC; i++) frm[i] = 17'(i);
    for (int i = 0; i < 4; i++) send_score(frm[i], i == 3);
    @(negedge clk);
    check("early_err", 32'(frame_err), 32'd1);
    check("early_valid", 32'(class_out_valid), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("early_novalid", 32'(class_out_valid), 32'd0);
    end
    @(posedge clk); #1;
    class_out_ready = 1'b1;
    send_frame(NC - 1, 0, 1);
    wait_idle();
    check("err_sticky", 32'(frame_err), 32'd1);

    // Missing last: error flagged but frame still completes.
    do_reset();
    check_reset_vals("rst1");
    frm = '{-17'sd7, 17'sd100, -17'sd1, 17'sd99, 17'sd100, 17'sd0, 17'sd8, -17'sd65536, 17'sd65535, 17'sd4};
    send_frame(-1, 0, 1);
    wait_idle();
    check("nolast_err", 32'(frame_err), 32'd1);

    // Reset in HOLD, then reset mid-frame.
    do_reset();
    class_out_ready = 1'b0;
    frm = '{17'sd1, 17'sd2, 17'sd3, 17'sd4, 17'sd50, 17'sd6, 17'sd7, 17'sd8, 17'sd9, 17'sd10};
    send_frame(NC - 1, 0, 1);
    @(negedge clk);
    check("hold_before_rst", 32'(class_out_valid), 32'd1);
    @(posedge clk); #1;
    exp_q.delete();
`ifdef FC_ARGMAX_SCORE_OUT_EN
    exps_q.delete();
`endif
    do_reset();
    check_reset_vals("rst_hold");
    for (int i = 0; i < 5; i++) send_score(frm[i], 1'b0);
    do_reset();
    check_reset_vals("rst_coll");
    repeat (5) begin
      @(negedge clk);
      check("no_stale", 32'(class_out_valid), 32'd0);
    end
    @(posedge clk); #1;
    class_out_ready = 1'b1;
    frm = '{17'sd9, 17'sd2, 17'sd3, 17'sd4, 17'sd5, 17'sd6, 17'sd7, 17'sd8, 17'sd11, 17'sd10};
    send_frame(NC - 1, 0, 1);
    wait_idle();

    // Random frames with input gaps and random consumer backpressure.
    fork
      begin
        for (int f = 0; f < 1000; f++) begin
          for (int i = 0; i < NC; i++) begin
            if ($urandom_range(0, 1) == 0) frm[i] = $signed(17'($urandom_range(0, 8))) - 17'sd4;
            else frm[i] = $signed(17'($urandom));
          end
          send_frame(NC - 1, 2, 1);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          class_out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    class_out_ready = 1'b1;

    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    check("rnd_err", 32'(frame_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
